// File: rtl/half_bus_master_pkg.sv
// Shared encodings for the half-word bus master: half-mask values, FSM states
// and the helper that picks the first phase of an access from its mask.
package half_bus_master_pkg;

  localparam logic [1:0] MASK_NONE = 2'b00;
  localparam logic [1:0] MASK_LO   = 2'b01;
  localparam logic [1:0] MASK_HI   = 2'b10;
  localparam logic [1:0] MASK_BOTH = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Low half always goes first; an empty mask skips the bus entirely.
  function automatic state_t first_state(input logic [1:0] mask);
    if ((mask & MASK_LO) != MASK_NONE) return ST_LO;
    if ((mask & MASK_HI) != MASK_NONE) return ST_HI;
    return ST_RESP;
  endfunction

endpackage

// File: rtl/half_bus_master_if.sv
// CPU request/response and narrow-bus signals of the half-word bus master.
// master = the converter's view, slave = the CPU + narrow bus side.
interface half_bus_master_if #(
  parameter int N  = 16,
  parameter int AW = 15
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [1:0]    req_mask;
  logic [N-1:0]  req_wdata;
  logic          rsp_valid;
  logic [N-1:0]  rsp_rdata;
  logic          bus_valid;
  logic          bus_ready;
  logic          bus_we;
  logic [AW:0]   bus_addr;
  logic [N/2-1:0] bus_wdata;
  logic [N/2-1:0] bus_rdata;

  modport master (
    input  req_valid, req_we, req_addr, req_mask, req_wdata, bus_ready, bus_rdata,
    output req_ready, rsp_valid, rsp_rdata, bus_valid, bus_we, bus_addr, bus_wdata
  );

  modport slave (
    output req_valid, req_we, req_addr, req_mask, req_wdata, bus_ready, bus_rdata,
    input  req_ready, rsp_valid, rsp_rdata, bus_valid, bus_we, bus_addr, bus_wdata
  );
endinterface

// File: rtl/half_bus_master.sv
// Splits N-bit CPU accesses into low-then-high N/2-bit bus transfers; 3 cycles
// accept-to-rsp with both halves, bus_ready stalls in place, rsp has no backpressure.
module half_bus_master
  import half_bus_master_pkg::*;
#(
  parameter int N  = 16,
  parameter int AW = 15
) (
  input  logic                clk,
  input  logic                rst,
  half_bus_master_if.master   hb
);

  state_t         state, state_nxt;
  logic           lat_we;
  logic [AW-1:0]  lat_addr;
  logic [1:0]     lat_mask;
  logic [N-1:0]   lat_wdata;
  logic           accept;
  logic           xfer;
  logic           src_we;
  logic [AW-1:0]  src_addr;
  logic [N-1:0]   src_wdata;

  assign accept = (state == ST_IDLE) && hb.req_valid;
  // bus_valid is high exactly in LO/HI, so bus_ready outside them is ignored.
  assign xfer   = hb.bus_valid && hb.bus_ready;

  // On the accept edge the latches are not loaded yet, so take the request directly.
  assign src_we    = accept ? hb.req_we    : lat_we;
  assign src_addr  = accept ? hb.req_addr  : lat_addr;
  assign src_wdata = accept ? hb.req_wdata : lat_wdata;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (hb.req_valid) state_nxt = first_state(hb.req_mask);
      ST_LO:   if (xfer) state_nxt = lat_mask[1] ? ST_HI : ST_RESP;
      ST_HI:   if (xfer) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_mask  <= MASK_NONE;
      lat_wdata <= '0;
    end else if (accept) begin
      lat_we    <= hb.req_we;
      lat_addr  <= hb.req_addr;
      lat_mask  <= hb.req_mask;
      lat_wdata <= hb.req_wdata;
    end
  end

  // Outputs come straight from flops, loaded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      hb.req_ready <= 1'b1;
      hb.rsp_valid <= 1'b0;
      hb.rsp_rdata <= '0;
      hb.bus_valid <= 1'b0;
      hb.bus_we    <= 1'b0;
      hb.bus_addr  <= '0;
      hb.bus_wdata <= '0;
    end else begin
      hb.req_ready <= (state_nxt == ST_IDLE);
      hb.rsp_valid <= (state_nxt == ST_RESP);
      hb.bus_valid <= (state_nxt == ST_LO) || (state_nxt == ST_HI);

      if (state_nxt != state) begin
        if (state_nxt == ST_LO) begin
          hb.bus_we    <= src_we;
          hb.bus_addr  <= {src_addr, 1'b0};
          hb.bus_wdata <= src_wdata[N/2-1:0];
        end else if (state_nxt == ST_HI) begin
          hb.bus_we    <= src_we;
          hb.bus_addr  <= {src_addr, 1'b1};
          hb.bus_wdata <= src_wdata[N-1:N/2];
        end else begin
          hb.bus_we    <= 1'b0;
        end
      end

      if (accept) begin
        hb.rsp_rdata <= '0;
      end else if (xfer && !lat_we) begin
        if (state == ST_LO) hb.rsp_rdata[N/2-1:0] <= hb.bus_rdata;
        else                hb.rsp_rdata[N-1:N/2] <= hb.bus_rdata;
      end
    end
  end

endmodule

// File: tb/tb_half_bus_master.sv
// Directed bench for half_bus_master: split writes, assembled reads, stalls, empty mask, mid-op reset.
module tb_half_bus_master;

  localparam int N  = 16;
  localparam int AW = 15;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  half_bus_master_if #(.N(N), .AW(AW)) hb ();

  half_bus_master #(.N(N), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .hb  (hb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits (bounded) for req_ready, then presents one request for exactly one edge.
  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [1:0] mask,
                       input logic [N-1:0] wdata);
    int waited;
    waited = 0;
    @(negedge clk);
    while (hb.req_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (waited >= 20) begin
      bad++;
      $display("FAIL issue_ready_timeout got req_ready=%b want 1", hb.req_ready);
    end
    hb.req_we    = we;
    hb.req_addr  = addr;
    hb.req_mask  = mask;
    hb.req_wdata = wdata;
    hb.req_valid = 1'b1;
    @(posedge clk);
    #1;
    hb.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if ({hb.req_ready, hb.rsp_valid, hb.rsp_rdata, hb.bus_valid, hb.bus_we, hb.bus_addr, hb.bus_wdata}
        !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00}) begin
      bad++;
      $display("FAIL reset_state got rdy=%b rv=%b rd=%h bv=%b we=%b ba=%h bw=%h want 1 0 0000 0 0 0000 00",
               hb.req_ready, hb.rsp_valid, hb.rsp_rdata, hb.bus_valid, hb.bus_we, hb.bus_addr, hb.bus_wdata);
    end
  endtask

  task automatic test_write_both();
    hb.bus_ready = 1'b1;
    issue(1'b1, 15'h0123, 2'b11, 16'hBEEF);
    @(negedge clk);
    total++;
    if ({hb.bus_valid, hb.bus_we, hb.bus_addr, hb.bus_wdata, hb.req_ready} !== {1'b1, 1'b1, 16'h0246, 8'hEF, 1'b0}) begin
      bad++;
      $display("FAIL wr_lo got v=%b we=%b a=%h d=%h rdy=%b want 1 1 0246 ef 0",
               hb.bus_valid, hb.bus_we, hb.bus_addr, hb.bus_wdata, hb.req_ready);
    end
    @(negedge clk);
    total++;
    if ({hb.bus_valid, hb.bus_we, hb.bus_addr, hb.bus_wdata} !== {1'b1, 1'b1, 16'h0247, 8'hBE}) begin
      bad++;
      $display("FAIL wr_hi got v=%b we=%b a=%h d=%h want 1 1 0247 be",
               hb.bus_valid, hb.bus_we, hb.bus_addr, hb.bus_wdata);
    end
    @(negedge clk);
    total++;
    if ({hb.rsp_valid, hb.rsp_rdata, hb.bus_valid, hb.req_ready} !== {1'b1, 16'h0000, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL wr_rsp got rv=%b rd=%h bv=%b rdy=%b want 1 0000 0 0",
               hb.rsp_valid, hb.rsp_rdata, hb.bus_valid, hb.req_ready);
    end
    @(negedge clk);
    total++;
    if ({hb.rsp_valid, hb.req_ready} !== 2'b01) begin
      bad++;
      $display("FAIL wr_after_rsp got rv=%b rdy=%b want 0 1", hb.rsp_valid, hb.req_ready);
    end
  endtask

  task automatic test_read_both();
    hb.bus_ready = 1'b1;
    issue(1'b0, 15'h0010, 2'b11, 16'hFFFF);
    @(negedge clk);
    total++;
    if ({hb.bus_valid, hb.bus_we, hb.bus_addr} !== {1'b1, 1'b0, 16'h0020}) begin
      bad++;
      $display("FAIL rd_lo got v=%b we=%b a=%h want 1 0 0020", hb.bus_valid, hb.bus_we, hb.bus_addr);
    end
    hb.bus_rdata = 8'h34;
    @(negedge clk);
    total++;
    if ({hb.bus_valid, hb.bus_we, hb.bus_addr} !== {1'b1, 1'b0, 16'h0021}) begin
      bad++;
      $display("FAIL rd_hi got v=%b we=%b a=%h want 1 0 0021", hb.bus_valid, hb.bus_we, hb.bus_addr);
    end
    hb.bus_rdata = 8'h12;
    @(negedge clk);
    total++;
    if ({hb.rsp_valid, hb.rsp_rdata} !== {1'b1, 16'h1234}) begin
      bad++;
      $display("FAIL rd_both_rsp got rv=%b rd=%h want 1 1234", hb.rsp_valid, hb.rsp_rdata);
    end
    @(negedge clk);
    total++;
    if (hb.rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rd_both_pulse got rv=%b want 0", hb.rsp_valid);
    end
  endtask

  task automatic test_read_single();
    hb.bus_ready = 1'b1;
    hb.bus_rdata = 8'hAB;
    issue(1'b0, 15'h0005, 2'b10, 16'h0000);
    @(negedge clk);
    total++;
    if ({hb.bus_valid, hb.bus_addr} !== {1'b1, 16'h000B}) begin
      bad++;
      $display("FAIL rd_hi_only_bus got v=%b a=%h want 1 000b", hb.bus_valid, hb.bus_addr);
    end
    @(negedge clk);
    total++;
    if ({hb.rsp_valid, hb.rsp_rdata, hb.bus_valid} !== {1'b1, 16'hAB00, 1'b0}) begin
      bad++;
      $display("FAIL rd_hi_only_rsp got rv=%b rd=%h bv=%b want 1 ab00 0", hb.rsp_valid, hb.rsp_rdata, hb.bus_valid);
    end
    hb.bus_rdata = 8'hCD;
    issue(1'b0, 15'h0005, 2'b01, 16'h0000);
    @(negedge clk);
    total++;
    if ({hb.bus_valid, hb.bus_addr} !== {1'b1, 16'h000A}) begin
      bad++;
      $display("FAIL rd_lo_only_bus got v=%b a=%h want 1 000a", hb.bus_valid, hb.bus_addr);
    end
    @(negedge clk);
    total++;
    if ({hb.rsp_valid, hb.rsp_rdata, hb.bus_valid} !== {1'b1, 16'h00CD, 1'b0}) begin
      bad++;
      $display("FAIL rd_lo_only_rsp got rv=%b rd=%h bv=%b want 1 00cd 0", hb.rsp_valid, hb.rsp_rdata, hb.bus_valid);
    end
  endtask

  task automatic test_stall();
    hb.bus_ready = 1'b0;
    issue(1'b1, 15'h0040, 2'b11, 16'h5A3C);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      total++;
      if ({hb.bus_valid, hb.bus_addr, hb.bus_wdata, hb.req_ready, hb.rsp_valid}
          !== {1'b1, 16'h0080, 8'h3C, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL stall_hold_%0d got v=%b a=%h d=%h rdy=%b rv=%b want 1 0080 3c 0 0",
                 i, hb.bus_valid, hb.bus_addr, hb.bus_wdata, hb.req_ready, hb.rsp_valid);
      end
    end
    @(posedge clk);
    #1 hb.bus_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({hb.bus_valid, hb.bus_addr, hb.bus_wdata} !== {1'b1, 16'h0080, 8'h3C}) begin
      bad++;
      $display("FAIL stall_lo_release got v=%b a=%h d=%h want 1 0080 3c", hb.bus_valid, hb.bus_addr, hb.bus_wdata);
    end
    @(negedge clk);
    total++;
    if ({hb.bus_valid, hb.bus_addr, hb.bus_wdata} !== {1'b1, 16'h0081, 8'h5A}) begin
      bad++;
      $display("FAIL stall_hi got v=%b a=%h d=%h want 1 0081 5a", hb.bus_valid, hb.bus_addr, hb.bus_wdata);
    end
    @(negedge clk);
    total++;
    if ({hb.rsp_valid, hb.bus_valid} !== 2'b10) begin
      bad++;
      $display("FAIL stall_rsp got rv=%b bv=%b want 1 0", hb.rsp_valid, hb.bus_valid);
    end
  endtask

  task automatic test_mask_none();
    hb.bus_ready = 1'b1;
    hb.bus_rdata = 8'hFF;
    issue(1'b0, 15'h0007, 2'b00, 16'h0000);
    @(negedge clk);
    total++;
    if ({hb.rsp_valid, hb.rsp_rdata, hb.bus_valid} !== {1'b1, 16'h0000, 1'b0}) begin
      bad++;
      $display("FAIL none_rsp got rv=%b rd=%h bv=%b want 1 0000 0", hb.rsp_valid, hb.rsp_rdata, hb.bus_valid);
    end
    @(negedge clk);
    total++;
    if ({hb.rsp_valid, hb.req_ready, hb.bus_valid} !== 3'b010) begin
      bad++;
      $display("FAIL none_after got rv=%b rdy=%b bv=%b want 0 1 0", hb.rsp_valid, hb.req_ready, hb.bus_valid);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    hb.bus_ready = 1'b1;
    hb.bus_rdata = 8'h99;
    issue(1'b0, 15'h0100, 2'b11, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({hb.bus_valid, hb.bus_addr} !== {1'b1, 16'h0201}) begin
      bad++;
      $display("FAIL midrst_in_hi got v=%b a=%h want 1 0201", hb.bus_valid, hb.bus_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({hb.bus_valid, hb.req_ready, hb.rsp_valid, hb.bus_addr, hb.rsp_rdata}
        !== {1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000}) begin
      bad++;
      $display("FAIL midrst_state got bv=%b rdy=%b rv=%b a=%h rd=%h want 0 1 0 0000 0000",
               hb.bus_valid, hb.req_ready, hb.rsp_valid, hb.bus_addr, hb.rsp_rdata);
    end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (hb.rsp_valid === 1'b1 || hb.bus_valid === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL midrst_quiet got %0d active cycles want 0", seen);
    end
    hb.bus_rdata = 8'h77;
    issue(1'b0, 15'h0002, 2'b01, 16'h0000);
    @(negedge clk);
    total++;
    if ({hb.bus_valid, hb.bus_addr} !== {1'b1, 16'h0004}) begin
      bad++;
      $display("FAIL midrst_fresh_bus got v=%b a=%h want 1 0004", hb.bus_valid, hb.bus_addr);
    end
    @(negedge clk);
    total++;
    if ({hb.rsp_valid, hb.rsp_rdata} !== {1'b1, 16'h0077}) begin
      bad++;
      $display("FAIL midrst_fresh_rsp got rv=%b rd=%h want 1 0077", hb.rsp_valid, hb.rsp_rdata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    total = 0;
    bad   = 0;
    rst          = 1'b1;
    hb.req_valid = 1'b0;
    hb.req_we    = 1'b0;
    hb.req_addr  = '0;
    hb.req_mask  = 2'b00;
    hb.req_wdata = '0;
    hb.bus_ready = 1'b0;
    hb.bus_rdata = '0;

    test_reset();
    test_write_both();
    test_read_both();
    test_read_single();
    test_stall();
    test_mask_none();
    test_reset_mid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
